// File: rtl/ms_pkg.sv
// Shared definitions for the ms_* arithmetic blocks.
// Operand widths, derived widths and the divider state encoding.
package ms_pkg;

  localparam int DW_DEF = 9;

  function automatic int qw_of(input int dw);
    return 2 * dw - 1;
  endfunction

  function automatic int cw_of(input int dw);
    return $clog2(2 * dw - 1);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIVIDE,
    SIGN_FIX,
    DONE
  } state_t;

endpackage

// File: rtl/ms_div_if.sv
// Start/ready bus between a requester and the ms_div divider.
// The requester drives operands and start; the divider returns results.
interface ms_div_if
  import ms_pkg::*;
#(
  parameter int DW = DW_DEF
);
  localparam int QW = qw_of(DW);

  logic          i_start;
  logic [QW-1:0] i_dividend;
  logic [DW-1:0] i_divisor;
  logic [QW-1:0] o_quotient;
  logic [DW-1:0] o_remainder;
  logic          o_ready;
  logic          o_done;
  logic          o_div_by_zero;
  logic          o_ovf;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_quotient, o_remainder, o_ready,
    input  o_done, o_div_by_zero, o_ovf
  );

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_quotient, o_remainder, o_ready,
    output o_done, o_div_by_zero, o_ovf
  );

endinterface

// File: rtl/ms_start_edge.sv
// Registers a level start request and flags its 0->1 transition.
// The pulse is combinational so the FSM sees it at the same edge.
module ms_start_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_rise
);

  logic start_d;
  logic start_q;

  assign start_d = i_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) start_q <= 1'b0;
    else       start_q <= start_d;
  end

  assign o_rise = i_start & ~start_q;

endmodule

// File: rtl/ms_div.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Divides a 2*DW-1 bit dividend by a DW bit divisor.
module ms_div
  import ms_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input logic     i_clk,
  input logic     i_rst,
  ms_div_if.slave bus
);

  localparam int QW = qw_of(DW);
  localparam int CW = cw_of(DW);

  localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};
  localparam logic [QW-1:0] QMAX = ~QMIN;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          sn_q, sn_d;
  logic          sd_q, sd_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [DW-1:0] remo_q, remo_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  logic          rise;
  logic [DW:0]   shifted;
  logic          keep;

  ms_start_edge u_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (bus.i_start),
    .o_rise  (rise)
  );

  // Partial remainder stays below |divisor|, so DW bits hold it
  // and the shifted trial value needs one more.
  assign shifted = {rem_q, dvd_q[QW-1]};
  assign keep    = shifted >= {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    sn_d    = sn_q;
    sd_d    = sd_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    ready_d = ready_q;
    done_d  = done_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          dvd_d   = bus.i_dividend;
          dvs_d   = bus.i_divisor;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          ready_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sn_d  = dvd_q[QW-1];
        sd_d  = dvs_q[DW-1];
        dvd_d = dvd_q[QW-1] ? -dvd_q : dvd_q;
        dvs_d = dvs_q[DW-1] ? -dvs_q : dvs_q;
        rem_d = '0;
        cnt_d = CW'(QW - 1);
        unique case (1'b1)
          (dvs_q == '0): begin
            dz_d    = 1'b1;
            quo_d   = '0;
            remo_d  = '0;
            state_d = DONE;
          end
          (dvd_q == QMIN && &dvs_q): begin
            ovf_d   = 1'b1;
            quo_d   = QMAX;
            remo_d  = '0;
            state_d = DONE;
          end
          default: state_d = DIVIDE;
        endcase
      end
      DIVIDE: begin
        rem_d = keep ? DW'(shifted - {1'b0, dvs_q})
                     : shifted[DW-1:0];
        dvd_d = {dvd_q[QW-2:0], keep};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = SIGN_FIX;
      end
      SIGN_FIX: begin
        quo_d   = (sn_q ^ sd_q) ? -dvd_q : dvd_q;
        remo_d  = sn_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        // Error paths enter with done low and spend one extra cycle here.
        if (done_q) begin
          done_d  = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      sn_q    <= 1'b0;
      sd_q    <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      sn_q    <= sn_d;
      sd_q    <= sd_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_quotient    = quo_q;
  assign bus.o_remainder   = remo_q;
  assign bus.o_ready       = ready_q;
  assign bus.o_done        = done_q;
  assign bus.o_div_by_zero = dz_q;
  assign bus.o_ovf         = ovf_q;

endmodule

// File: tb/tb_ms_div.sv
// Scoreboard bench for ms_div: directed divisions, error paths,
// start-edge handling and asynchronous reset.
module tb_ms_div;
  import ms_pkg::*;

  localparam int DW = 9;
  localparam int QW = 17;

  typedef struct {
    int    q;
    int    r;
    int    dz;
    int    ov;
    int    lat;
    int    trig;
    string name;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ms_div_if #(.DW(DW)) bus ();

  ms_div #(.DW(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got q=%0d want none",
                 $signed(bus.o_quotient));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ":quot"}, $signed(bus.o_quotient), e.q);
        chk({e.name, ":rem"}, $signed(bus.o_remainder), e.r);
        chk({e.name, ":dz"}, bus.o_div_by_zero, e.dz);
        chk({e.name, ":ovf"}, bus.o_ovf, e.ov);
        chk({e.name, ":lat"}, cyc - e.trig, e.lat);
        chk({e.name, ":ready"}, bus.o_ready, 0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got 0 want 1");
    end
  endtask

  task automatic push(input string name, input int q, input int r,
                      input int dz, input int ov, input int lat);
    exp_t e;
    e.name = name;
    e.q    = q;
    e.r    = r;
    e.dz   = dz;
    e.ov   = ov;
    e.lat  = lat;
    e.trig = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic op(input string name, input int dvd, input int dvs,
                    input int q, input int r, input int dz,
                    input int ov, input int lat, input bit track);
    wait_ready();
    bus.i_dividend = QW'(dvd);
    bus.i_divisor  = DW'(dvs);
    bus.i_start    = 1'b1;
    if (track) push(name, q, r, dz, ov, lat);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ":ready"}, bus.o_ready, 1);
    chk({tag, ":done"}, bus.o_done, 0);
    chk({tag, ":quot"}, $signed(bus.o_quotient), 0);
    chk({tag, ":rem"}, $signed(bus.o_remainder), 0);
    chk({tag, ":dz"}, bus.o_div_by_zero, 0);
    chk({tag, ":ovf"}, bus.o_ovf, 0);
  endtask

  initial begin
    bus.i_start    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    op("294/14",      294,    14,   21,   0, 0, 0, 19, 1);
    op("-20/-1",      -20,    -1,   20,   0, 0, 0, 19, 1);
    op("3200/100",    3200,   100,  32,   0, 0, 0, 19, 1);
    op("-320/10",     -320,   10,   -32,  0, 0, 0, 19, 1);
    op("7/-2",        7,      -2,   -3,   1, 0, 0, 19, 1);
    op("-7/2",        -7,     2,    -3,  -1, 0, 0, 19, 1);
    op("65535/-256",  65535,  -256, -255, 255, 0, 0, 19, 1);
    op("-65536/1",    -65536, 1,    -65536, 0, 0, 0, 19, 1);
    op("-65536/-256", -65536, -256, 256,  0, 0, 0, 19, 1);
    op("100/0",       100,    0,    0,    0, 1, 0, 2, 1);
    op("-65536/-1",   -65536, -1,   65535, 0, 0, 1, 2, 1);
    op("10/3",        10,     3,    3,    1, 0, 0, 19, 1);
    drain();

    // Held-high start: exactly one operation.
    wait_ready();
    bus.i_dividend = QW'(1000);
    bus.i_divisor  = DW'(7);
    bus.i_start    = 1'b1;
    push("held", 142, 6, 0, 0, 19);
    repeat (45) @(negedge clk);
    bus.i_start = 1'b0;
    drain();

    // Fresh edge while dividing must be ignored.
    op("5000/-9", 5000, -9, -555, 5, 0, 0, 19, 1);
    repeat (4) @(negedge clk);
    bus.i_dividend = QW'(9);
    bus.i_divisor  = DW'(3);
    bus.i_start    = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    drain();
    repeat (25) @(negedge clk);

    // Asynchronous reset mid-divide.
    op("abort", 300, 7, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_idle_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op("300/7", 300, 7, 42, 6, 0, 0, 19, 1);
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ms_div.md
Name: ms_div

Overview:
- Sequential signed divider, the inverse of the team's ms_mult shift-add multiplier.
- Takes a double-width product-style dividend and a single-width divisor, and returns quotient and remainder.
- Restoring shift-subtract, one quotient bit per clock.
- Sits beside ms_mult on the same board-level start/ready scheme, so a multiply result can be fed back and checked.

Parameters:
- DW, 9, operand width in bits; divisor and remainder width.
- QW, 2*DW-1 (17), dividend and quotient width; derived, not overridable.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_start  in  1  start request; level input, rising edge triggers.
- i_dividend  in  QW  signed two's-complement dividend.
- i_divisor  in  DW  signed two's-complement divisor.
- o_quotient  out  QW  signed quotient.
- o_remainder  out  DW  signed remainder.
- o_ready  out  1  high only in IDLE; start accepted.
- o_done  out  1  one-cycle pulse; results valid and stable from this cycle.
- o_div_by_zero  out  1  sticky until next accepted start.
- o_ovf  out  1  sticky until next accepted start.

Behaviour:
- Reset values (async, immediate): state IDLE; o_ready=1; all other outputs 0; start edge register 0.
- Reset mid-operation aborts the division; there is no partial result.
- Start edge detection:
  - start_q is registered i_start.
  - The trigger is i_start=1 && start_q=0, sampled at an edge while in IDLE.
  - A held-high i_start does not retrigger.
  - Edges outside IDLE are ignored and not queued.
- FSM state IDLE: on trigger, latch operands, clear the flags, go to LOAD; o_ready drops at this edge.
- FSM state LOAD:
  - Record signs; form magnitudes |dividend| (QW+1 bits internally) and |divisor|.
  - Divisor==0: o_div_by_zero=1, quotient=0, remainder=0, go to DONE.
  - Dividend==-2^(QW-1) and divisor==-1: o_ovf=1, quotient=2^(QW-1)-1 (saturate), remainder=0, go to DONE.
  - Otherwise go to DIVIDE with the iteration counter set to QW-1.
- FSM state DIVIDE, each cycle:
  - Partial remainder (DW+1 bits) shifts left, taking the next dividend MSB.
  - Subtract |divisor|; if the result is non-negative keep it and set the quotient bit to 1, else restore and set it to 0.
  - The counter decrements; after QW iterations go to SIGN_FIX.
- FSM state SIGN_FIX:
  - Quotient negated if the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
  - Register o_quotient and o_remainder; go to DONE.
- FSM state DONE: o_done=1 for exactly one cycle, then IDLE; o_ready rises at that edge.
- Latency, with the trigger edge at T0:
  - Normal: o_done high in the cycle after edge T0+QW+2, i.e. 19 cycles for DW=9.
  - Zero or overflow path: o_done high after edge T0+2.
- Outputs hold their last result through IDLE until the next SIGN_FIX or LOAD error path.
- Invariants: |remainder| < |divisor| always; dividend == quotient*divisor + remainder whenever no flag is set.
- A DW-bit signed divisor of -2^(DW-1) is legal; its magnitude needs DW bits unsigned, so internal magnitudes are DW+1 wide.

Decomposition:
- Shared package ms_pkg:
  - Default DW.
  - The QW derivation (localparam or function).
  - State enum {IDLE, LOAD, DIVIDE, SIGN_FIX, DONE}.
  - Counter width $clog2(QW).
- One sub-module, ms_start_edge: registers i_start and outputs the rising-edge pulse. ms_mult may reuse it.
- The datapath stays inline.

Test Plan:
- Dividend 294, divisor 14, start edge -> quotient 21, remainder 0, no flags, o_done exactly 19 cycles after trigger, o_ready low throughout.
- Dividend -20, divisor -1 -> quotient 20, remainder 0.
- Dividend 3200, divisor 100 -> quotient 32, remainder 0.
- Dividend -320, divisor 10 -> quotient -32, remainder 0.
- Sign rules:
  - 7 / -2 -> quotient -3, remainder 1.
  - -7 / 2 -> quotient -3, remainder -1.
  - 65535 / -256 -> quotient -255, remainder 255.
- Error paths:
  - 100 / 0 -> o_div_by_zero=1, quotient 0, remainder 0, o_done after 2 cycles.
  - -65536 / -1 -> o_ovf=1, quotient 65535, remainder 0.
  - A following 10 / 3 clears both flags and returns 3 r 1.
- Control:
  - i_start held high across two results -> only one operation.
  - A new 0->1 edge mid-DIVIDE -> ignored; the result is unchanged.
  - i_rst pulsed mid-DIVIDE -> all outputs 0 and o_ready=1 immediately (asynchronously).
  - The next start then completes normally.
